// File: rtl/reg_fifo_if.sv
// Handshake bundle for reg_fifo: push side (enable/data/ready), pop side
// (rd_en/outa/valid), occupancy and sticky error flags.
interface reg_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();
  localparam int AW = $clog2(DEPTH);

  logic             enable;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             rd_en;
  logic [WIDTH-1:0] outa;
  logic             valid;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;
  logic             clr_err;
`ifdef REG_FIFO_ALMOST_FULL_EN
  logic             almost_full;
`endif

`ifdef REG_FIFO_ALMOST_FULL_EN
  modport master (
    output enable, data, rd_en, clr_err,
    input  ready, outa, valid, count, overflow, underflow, almost_full
  );
  modport slave (
    input  enable, data, rd_en, clr_err,
    output ready, outa, valid, count, overflow, underflow, almost_full
  );
`else
  modport master (
    output enable, data, rd_en, clr_err,
    input  ready, outa, valid, count, overflow, underflow
  );
  modport slave (
    input  enable, data, rd_en, clr_err,
    output ready, outa, valid, count, overflow, underflow
  );
`endif
endinterface

// File: rtl/reg_fifo.sv
// DEPTH-entry first-word-fall-through FIFO with EMPTY/PARTIAL/FULL tracking and
// sticky overflow/underflow flags. Define REG_FIFO_ALMOST_FULL_EN for almost_full.
module reg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
`ifdef REG_FIFO_ALMOST_FULL_EN
  , parameter int AF_LEVEL = DEPTH - 1
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  reg_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push, pop;
  logic             set_ov, set_un;
  logic             overflow, underflow;

  // A full FIFO still takes a push when the same edge frees a slot.
  assign push   = bus.enable && (state != ST_FULL || bus.rd_en);
  assign pop    = bus.rd_en && (state != ST_EMPTY);
  assign set_ov = bus.enable && (state == ST_FULL) && !bus.rd_en;
  assign set_un = bus.rd_en && (state == ST_EMPTY);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;

    case (state)
      ST_EMPTY: begin
        if (push) state_nxt = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push && !pop && count_nxt == FULL_CNT) state_nxt = ST_FULL;
        else if (pop && !push && count_nxt == '0)  state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (pop && !push) state_nxt = ST_PARTIAL;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_EMPTY;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A new error event wins over a clear on the same edge.
      overflow  <= set_ov | (overflow  & ~bus.clr_err);
      underflow <= set_un | (underflow & ~bus.clr_err);
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is tracked by state/count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data;
  end

`ifdef REG_FIFO_ALMOST_FULL_EN
  localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
  logic almost_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) almost_full <= 1'b0;
    else          almost_full <= (count_nxt >= AF_CNT);
  end

  assign bus.almost_full = almost_full;
`endif

  assign bus.valid     = (state != ST_EMPTY);
  assign bus.ready     = (state != ST_FULL);
  assign bus.count     = count;
  assign bus.outa      = (state != ST_EMPTY) ? mem[rd_ptr] : '0;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_reg_fifo.sv
// Scoreboard bench for reg_fifo: a reference queue and occupancy model predict
// every output each cycle; popped words are compared against the queue head.
module tb_reg_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic reset_n;

  reg_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef REG_FIFO_ALMOST_FULL_EN
  localparam int AF_LEVEL = 3;
  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
`else
  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] sbq[$];
  int   m_count;
  logic m_ov;
  logic m_un;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("valid", 32'(bus.valid), 32'(m_count > 0));
    check("ready", 32'(bus.ready), 32'(m_count < DEPTH));
    check("count", 32'(bus.count), 32'(m_count));
    check("overflow", 32'(bus.overflow), 32'(m_ov));
    check("underflow", 32'(bus.underflow), 32'(m_un));
    if (m_count > 0) check("outa_head", 32'(bus.outa), 32'(sbq[0]));
    else             check("outa_empty", 32'(bus.outa), 32'd0);
`ifdef REG_FIFO_ALMOST_FULL_EN
    check("almost_full", 32'(bus.almost_full), 32'(m_count >= AF_LEVEL));
`endif
  endtask

  task automatic model_reset();
    sbq.delete();
    m_count = 0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
  endtask

  // Drive one cycle of stimulus, update the model, then sample #1 after the edge.
  task automatic step(input logic en, input logic [WIDTH-1:0] d, input logic rd, input logic clr);
    logic push_ok, pop_ok, set_ov, set_un;
    logic [WIDTH-1:0] exp_word;
    bus.enable  = en;
    bus.data    = d;
    bus.rd_en   = rd;
    bus.clr_err = clr;
    push_ok = en && (m_count < DEPTH || rd);
    pop_ok  = rd && (m_count > 0);
    set_ov  = en && (m_count == DEPTH) && !rd;
    set_un  = rd && (m_count == 0);
    if (pop_ok) begin
      exp_word = sbq.pop_front();
      check("pop_data", 32'(bus.outa), 32'(exp_word));
    end
    if (push_ok) sbq.push_back(d);
    if (push_ok && !pop_ok)      m_count++;
    else if (pop_ok && !push_ok) m_count--;
    m_ov = set_ov | (m_ov & ~clr);
    m_un = set_un | (m_un & ~clr);
    @(posedge clk);
    #1;
    bus.enable  = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [WIDTH-1:0] wl [4];
    wl[0] = 8'h11; wl[1] = 8'h22; wl[2] = 8'h33; wl[3] = 8'h44;

    reset_n     = 1'b0;
    bus.enable  = 1'b0;
    bus.data    = '0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill, overflow attempt, drain.
    for (int i = 0; i < 4; i++) step(1'b1, wl[i], 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Refill, then push+pop while full.
    for (int i = 0; i < 4; i++) step(1'b1, wl[i], 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Push+pop into empty: pop rejected, push accepted.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    // Underflow set and clear on the same edge: set wins.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Pointer wrap at steady occupancy of 2.
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'hF1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 10; i < 13; i++) step(1'b1, 8'(i), 1'b1, 1'b0);

    // Asynchronous reset mid-stream, away from any clock edge.
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_valid", 32'(bus.valid), 32'd0);
    check("async_rst_count", 32'(bus.count), 32'd0);
    check("async_rst_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Almost-full threshold crossing (checked every cycle when enabled).
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_fifo.md
Name: reg_fifo

Overview:
- Parametrised successor to the single-stage enable register: a DEPTH-entry synchronous FIFO of WIDTH-bit words with first-word-fall-through output.
- Keeps the enable/data/outa naming of the register block, so existing register drivers and monitors extend to it with a pop port.
- Adds occupancy tracking, a full/empty state machine, simultaneous push/pop handling and sticky error flags.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- AW, $clog2(DEPTH), derived pointer width; not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  push request.
- data  input  WIDTH  push data, sampled when a push is accepted.
- ready  output  1  registered; high when not full.
- rd_en  input  1  pop request.
- outa  output  WIDTH  head-of-queue data, valid while valid=1.
- valid  output  1  registered; high when not empty.
- count  output  AW+1  registered occupancy, 0..DEPTH.
- overflow  output  1  sticky; set on push attempt while full with no pop.
- underflow  output  1  sticky; set on pop attempt while empty.
- clr_err  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (reset_n low, asynchronous): state EMPTY, wr_ptr=rd_ptr=0, count=0, valid=0, ready=1, outa=0, overflow=0, underflow=0. Storage array contents are not reset.
- Reset applied mid-operation discards all stored entries immediately. First push after release behaves as push into EMPTY.
- Push accepted: enable && (state!=FULL || rd_en).
- Pop accepted: rd_en && state!=EMPTY.
- Accepted push writes data to mem[wr_ptr] and increments wr_ptr modulo DEPTH. Wrap from DEPTH-1 to 0 is natural.
- Accepted pop increments rd_ptr modulo DEPTH.
- FWFT output: outa = mem[rd_ptr] when valid=1, else 0.
  - Push into EMPTY at edge N makes valid=1 and outa=data after edge N (1-cycle latency).
  - Pop at edge N presents the next entry after edge N.
- State machine: EMPTY, PARTIAL, FULL.
  - EMPTY: push -> PARTIAL. If DEPTH would be reached it cannot happen here, since DEPTH>=2.
  - PARTIAL: push only, with count becoming DEPTH -> FULL. Pop only, with count becoming 0 -> EMPTY. Push+pop or neither -> stay.
  - FULL: pop only -> PARTIAL. Push+pop -> stay FULL, both accepted. Push only -> stay, push dropped.
- count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
- valid = (state!=EMPTY); ready = (state!=FULL). Both derive from the registered state, with no combinational path from inputs.
- Simultaneous push+pop in EMPTY: pop rejected (underflow set), push accepted.
- Simultaneous push+pop in FULL: both accepted; outa advances and the new word goes to the tail.
- overflow set on edge where enable && state==FULL && !rd_en.
- underflow set on edge where rd_en && state==EMPTY.
- clr_err clears both flags; a set condition on the same edge takes priority over the clear.
- Rejected operations do not change pointers, count or storage.

Optional Feature:
- Macro: REG_FIFO_ALMOST_FULL_EN.
- Defined:
  - adds parameter AF_LEVEL (default DEPTH-1, range 1..DEPTH) and output port almost_full (1 bit, registered).
  - almost_full = (next count >= AF_LEVEL), updated on the same edge as count; reset value 0.
- Not defined: neither the parameter nor the port exists; all other behaviour is identical.

Test Plan:
- Reset then 4 pushes of 0x11,0x22,0x33,0x44 (DEPTH=4) -> count 1,2,3,4; ready=0 after 4th edge; outa=0x11 from edge after first push.
- Full, push 0x55 with rd_en=0 -> 0x55 dropped, overflow=1, count=4; 4 pops -> outa 0x11,0x22,0x33,0x44 then valid=0.
- Full, push 0x66 with rd_en=1 -> both accepted, count stays 4; pop order 0x22,0x33,0x44,0x66.
- Empty, rd_en=1 with enable=1 data=0xA5 -> underflow=1, count=1, outa=0xA5 next cycle; clr_err pulse -> underflow=0.
- 10 push/pop pairs of 0x00..0x09 at count 2 -> pointer wrap, FIFO order preserved, count stays 2; assert reset_n low mid-sequence -> valid=0, count=0, ready=1 without waiting for a clock edge.
- With REG_FIFO_ALMOST_FULL_EN and AF_LEVEL=3: 3 pushes -> almost_full=1 after third edge; 1 pop -> almost_full=0.
